// File: rtl/msg_tx_scheduler.sv
// Round-robin arbiter that shares one 9-bit frame serializer among NREQ sources.
// Issues a one-cycle send/grant, then times the frame and the inter-frame gap.
module msg_tx_scheduler #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned BIT_CYCLES = 1024,
    parameter int unsigned FRAME_BITS = 9,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned CNT_W      = 14
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [NREQ-1:0]     i_req,
    input  logic [5*NREQ-1:0]   i_req_msg,
    input  logic [NREQ-1:0]     i_req_mode,
    output logic [NREQ-1:0]     o_grant,
    output logic                o_send,
    output logic [4:0]          o_msg_out,
    output logic                o_mode_out,
    output logic                o_busy,
    output logic                o_frame_done
);

    localparam int unsigned     PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(FRAME_BITS * BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_TX    = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt;
    logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [PTR_W-1:0]   r_win, w_win_nxt;
    logic [PTR_W-1:0]   w_win;
    logic               w_found;
    logic [4:0]         w_msg;
    logic               w_mode;

    logic [NREQ-1:0]    w_grant_nxt;
    logic               w_send_nxt;
    logic [4:0]         w_msg_nxt;
    logic               w_mode_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // First requesting source at or after the round-robin pointer, wrapping.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(r_rr_ptr) + k) % NREQ;
            if (!w_found && i_req[PTR_W'(idx)]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        w_msg  = '0;
        w_mode = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (PTR_W'(j) == w_win) begin
                w_msg  = i_req_msg[5*j +: 5];
                w_mode = i_req_mode[j];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_rr_ptr <= '0;
            r_win    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_win    <= w_win_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_rr_ptr_nxt = r_rr_ptr;
        w_win_nxt    = r_win;
        case (r_state)
            S_IDLE: begin
                if (i_en && w_found) begin
                    w_state_nxt = S_ISSUE;
                    w_win_nxt   = w_win;
                end
            end
            S_ISSUE: begin
                w_rr_ptr_nxt = (r_win == PTR_W'(NREQ - 1)) ? '0 : r_win + 1'b1;
                w_timer_nxt  = '0;
                w_state_nxt  = S_TX;
            end
            S_TX: begin
                if (r_timer == TX_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_GAP: begin
                if (r_timer == GAP_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values look ahead so the registered outputs line up with the state.
    always_comb begin
        w_send_nxt  = 1'b0;
        w_grant_nxt = '0;
        w_msg_nxt   = o_msg_out;
        w_mode_nxt  = o_mode_out;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_GAP) && (w_timer_nxt == GAP_LAST);
        if (r_state == S_IDLE && w_state_nxt == S_ISSUE) begin
            w_send_nxt  = 1'b1;
            w_grant_nxt = NREQ'(1) << w_win;
            w_msg_nxt   = w_msg;
            w_mode_nxt  = w_mode;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_grant      <= '0;
            o_send       <= 1'b0;
            o_msg_out    <= '0;
            o_mode_out   <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_grant      <= w_grant_nxt;
            o_send       <= w_send_nxt;
            o_msg_out    <= w_msg_nxt;
            o_mode_out   <= w_mode_nxt;
            o_busy       <= w_busy_nxt;
            o_frame_done <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_msg_tx_scheduler.sv
// Scoreboard bench for msg_tx_scheduler: a transaction-level model queues the expected
// sends and frame_done pulses; a monitor pops and compares them as the DUT emits them.
module tb_msg_tx_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned BITC  = 4;
    localparam int unsigned FBITS = 9;
    localparam int unsigned GAPC  = 2;
    localparam int unsigned CNTW  = 14;
    localparam int unsigned DONE_OFS = 1 + FBITS * BITC + GAPC;  // request cycle -> frame_done
    localparam int unsigned FREE_OFS = DONE_OFS + 1;             // request cycle -> next IDLE

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NREQ-1:0]   req;
    logic [5*NREQ-1:0] req_msg;
    logic [NREQ-1:0]   req_mode;
    logic [NREQ-1:0]   grant;
    logic              send;
    logic [4:0]        msg_out;
    logic              mode_out;
    logic              busy;
    logic              frame_done;

    msg_tx_scheduler #(
        .NREQ(NREQ), .BIT_CYCLES(BITC), .FRAME_BITS(FBITS), .GAP_CYCLES(GAPC), .CNT_W(CNTW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req), .i_req_msg(req_msg),
        .i_req_mode(req_mode), .o_grant(grant), .o_send(send), .o_msg_out(msg_out),
        .o_mode_out(mode_out), .o_busy(busy), .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned     cyc;
        logic [NREQ-1:0] grant;
        logic [4:0]      msg;
        logic            mode;
    } exp_t;

    exp_t        send_q[$];
    int unsigned done_q[$];
    int unsigned cyc     = 0;
    int unsigned m_free  = 0;
    int unsigned m_ptr   = 0;
    logic [4:0]  m_msg   = '0;
    logic        m_mode  = 1'b0;
    int unsigned checks  = 0;
    int unsigned errs    = 0;
    int unsigned n_sends = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errs++;
        $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    endtask

    // Reference model: a free scheduler picks the first requester from its pointer.
    always @(posedge clk) begin
        if (!rst && en && req != '0 && cyc >= m_free) begin
            int unsigned w;
            exp_t e;
            w = m_ptr;
            while (!req[w]) w = (w + 1) % NREQ;
            e.cyc   = cyc + 1;
            e.grant = NREQ'(1 << w);
            e.msg   = req_msg[5*w +: 5];
            e.mode  = req_mode[w];
            send_q.push_back(e);
            done_q.push_back(cyc + DONE_OFS);
            m_free = cyc + FREE_OFS;
            m_ptr  = (w + 1) % NREQ;
        end
        cyc = cyc + 1;
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (send) begin
                n_sends++;
                if (send_q.size() == 0) begin
                    fail("unexpected_send", {28'd0, grant}, 32'd0);
                end else begin
                    exp_t e;
                    e = send_q.pop_front();
                    chk("send_cycle", cyc, e.cyc);
                    chk("grant", {28'd0, grant}, {28'd0, e.grant});
                    chk("msg_out", {27'd0, msg_out}, {27'd0, e.msg});
                    chk("mode_out", {31'd0, mode_out}, {31'd0, e.mode});
                    m_msg  = e.msg;
                    m_mode = e.mode;
                end
            end else begin
                if (grant != '0) fail("grant_without_send", {28'd0, grant}, 32'd0);
                if (send_q.size() != 0 && send_q[0].cyc < cyc) begin
                    fail("missing_send", 32'd0, send_q[0].cyc);
                    void'(send_q.pop_front());
                end
                chk("msg_hold", {27'd0, msg_out}, {27'd0, m_msg});
                chk("mode_hold", {31'd0, mode_out}, {31'd0, m_mode});
            end
            if (frame_done) begin
                if (done_q.size() == 0) fail("unexpected_frame_done", 32'd1, 32'd0);
                else chk("frame_done_cycle", cyc, done_q.pop_front());
            end else if (done_q.size() != 0 && done_q[0] < cyc) begin
                fail("missing_frame_done", 32'd0, done_q[0]);
                void'(done_q.pop_front());
            end
            chk("busy", {31'd0, busy}, {31'd0, (cyc < m_free)});
        end
    end

    // Advance one cycle; a source drops its request once it sees its grant pulse.
    task automatic step();
        @(negedge clk);
        #1;
        req = req & ~grant;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic wait_send(input int unsigned budget);
        int unsigned k;
        k = 0;
        do begin
            step();
            k++;
        end while (!send && k < budget);
        if (!send) fail("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic model_reset();
        send_q.delete();
        done_q.delete();
        m_free = 0;
        m_ptr  = 0;
        m_msg  = '0;
        m_mode = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, {28'd0, grant}, 32'd0);
        chk({tag, "_send"}, {31'd0, send}, 32'd0);
        chk({tag, "_msg"}, {27'd0, msg_out}, 32'd0);
        chk({tag, "_mode"}, {31'd0, mode_out}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, frame_done}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("rst");
        steps(2);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned base;
        rst      = 1'b1;
        en       = 1'b0;
        req      = '0;
        req_msg  = '0;
        req_mode = '0;
        steps(3);
        do_reset();
        step();

        // Single request from source 0
        en = 1'b1;
        req_msg[4:0] = 5'b10110;
        req_mode[0]  = 1'b1;
        req = 4'b0001;
        wait_send(10);
        steps(45);

        // Round robin with all four sources pending, from a fresh pointer
        do_reset();
        step();
        req_msg  = 20'($urandom);
        req_mode = 4'($urandom);
        req = 4'b1111;
        steps(4 * FREE_OFS + 10);

        // Pointer wrap: after source 3, 0 wins, then 3 wins over a re-raised 0
        req_msg = 20'($urandom);
        req = 4'b1001;
        wait_send(10);
        req = req | 4'b0001;
        steps(2 * FREE_OFS + 10);

        // Enable gating
        en = 1'b0;
        req = 4'b0010;
        base = n_sends;
        steps(50);
        chk("en_gate_no_send", n_sends, base);
        en = 1'b1;
        wait_send(5);
        steps(10);
        en = 1'b0;
        steps(FREE_OFS);
        en = 1'b1;

        // Reset ten cycles into TX
        req = 4'b0001;
        wait_send(5);
        steps(11);
        do_reset();
        req = 4'b0100;
        wait_send(5);
        steps(45);

        // Request raised and dropped entirely within GAP is never seen
        req = 4'b0010;
        wait_send(5);
        steps(37);
        req = 4'b0001;
        step();
        req = 4'b0000;
        base = n_sends;
        steps(15);
        chk("short_req_no_send", n_sends, base);

        // Randomized traffic
        for (int unsigned c = 0; c < 2500; c++) begin
            step();
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 15) == 0) begin
                    req[i]            = 1'b1;
                    req_msg[5*i +: 5] = 5'($urandom);
                    req_mode[i]       = 1'($urandom);
                end
            end
            en = ($urandom_range(0, 9) != 0);
        end

        // Drain
        en  = 1'b1;
        req = '0;
        steps(FREE_OFS + 10);
        chk("send_q_drained", send_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end

endmodule
